dbg_arb: RTL and testbench

- Arbitrates the single debug register bus (seg/addr, wen, ren, wdata, rdata) between N_REQ independent masters, e.g. the PYNQ AXI bridge and a UART command engine.
- Accepts one transaction at a time with round-robin fairness and drives the bus.
- Holds the address stable through the fixed read latency of the debug controller, then returns read data or a write acknowledge to the owning master only.

---
 rtl/dbg_arb_pkg.sv | 38 +++
 rtl/dbg_arb_if.sv | 32 +++
 rtl/dbg_rr_pick.sv | 34 +++
 rtl/dbg_arb.sv | 147 ++++++++++++++
 tb/tb_dbg_arb.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dbg_arb_pkg.sv
// Shared types and constants for the debug-bus arbiter: bus address layout,
// data byte, FSM state encoding and the default read latency.
package dbg_arb_pkg;

   localparam int Max_req = 8;
   localparam int Rd_lat  = 2;

   typedef logic [$clog2(Max_req)-1:0] req_id_t;
   typedef logic [7:0]                 byte_t;

   typedef enum logic [1:0] {
      SEG_CTL = 2'd0,
      SEG_IO  = 2'd1,
      SEG_ROM = 2'd2,
      SEG_RAM = 2'd3
   } seg_t;

   typedef struct packed {
      seg_t  seg;
      byte_t idx;
   } addr_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } arb_state_t;

   localparam addr_t Ctl_pc_lo   = '{seg: SEG_CTL, idx: 8'h00};
   localparam addr_t Ctl_sys_rst = '{seg: SEG_CTL, idx: 8'h10};
   localparam addr_t Io_rom_out2 = '{seg: SEG_IO,  idx: 8'h02};

   function automatic addr_t mk_addr(input seg_t seg, input byte_t idx);
      return '{seg: seg, idx: idx};
   endfunction

endpackage

// File: rtl/dbg_arb_if.sv
// Request/response handshake of all masters plus the debug register bus.
// The arbiter takes the slave view; the masters and the bus model take the rest.
interface dbg_arb_if import dbg_arb_pkg::*; #(
   parameter int N_REQ = 2
) ();

   logic  [N_REQ-1:0] req_valid;
   logic  [N_REQ-1:0] req_ready;
   logic  [N_REQ-1:0] req_we;
   addr_t [N_REQ-1:0] req_addr;
   byte_t [N_REQ-1:0] req_wdata;
   logic  [N_REQ-1:0] rsp_valid;
   byte_t             rsp_rdata;

   addr_t             dbg_addr;
   logic              dbg_wen;
   logic              dbg_ren;
   byte_t             dbg_wdata;
   byte_t             dbg_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, dbg_rdata,
      output req_ready, rsp_valid, rsp_rdata,
      output dbg_addr, dbg_wen, dbg_ren, dbg_wdata
   );

endinterface

// File: rtl/dbg_rr_pick.sv
// Combinational round-robin search: first asserted request strictly after
// the pointer, wrapping from N_REQ-1 back to 0.
module dbg_rr_pick import dbg_arb_pkg::*; #(
   parameter int N_REQ = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  req_id_t          ptr_i,
   output logic [N_REQ-1:0] grant_o,
   output req_id_t          idx_o,
   output logic             any_o
);

   logic found;

   // NOTE: every output gets a default before the search so no path through
   // the loops leaves a signal unassigned, which would infer a latch.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_i[i] && (i == (int'(ptr_i) + k) % N_REQ)) begin
               found      = 1'b1;
               grant_o[i] = 1'b1;
               idx_o      = req_id_t'(i);
            end
         end
      end
   end

   assign any_o = found;

endmodule

// File: rtl/dbg_arb.sv
// Round-robin arbiter for the shared debug register bus: one transaction in
// flight, address held through the read latency, response to the owner only.
module dbg_arb import dbg_arb_pkg::*; #(
   parameter int N_REQ  = 2,
   parameter int RD_LAT = Rd_lat
) (
   input  logic      clk,
   input  logic      rst_n,
   dbg_arb_if.slave  bus,
   output logic      busy
);

   localparam int Cnt_w = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   typedef logic [Cnt_w-1:0] cnt_t;
   localparam cnt_t Cnt_init = cnt_t'(RD_LAT - 1);

   arb_state_t       state_q, state_d;
   req_id_t          ptr_q, ptr_d;
   logic [N_REQ-1:0] owner_q, owner_d;
   logic             we_q, we_d;
   addr_t            addr_q, addr_d;
   byte_t            wdata_q, wdata_d;
   logic             wen_q, wen_d;
   logic             ren_q, ren_d;
   cnt_t             cnt_q, cnt_d;
   logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
   byte_t            rsp_rdata_q, rsp_rdata_d;
   logic             arm_q, arm_d;

   logic [N_REQ-1:0] grant;
   req_id_t          grant_idx;
   logic             grant_any;
   logic             can_accept;

   dbg_rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req_i   (bus.req_valid),
      .ptr_i   (ptr_q),
      .grant_o (grant),
      .idx_o   (grant_idx),
      .any_o   (grant_any)
   );

   // Ready must answer valid within the accept cycle so that an ACK cycle can
   // also accept; arm_q keeps it low while rst_n is asserted and for one edge after.
   assign can_accept    = arm_q && ((state_q == IDLE) || (state_q == ACK));
   assign bus.req_ready = can_accept ? grant : '0;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wen_d       = 1'b0;
      ren_d       = 1'b0;
      cnt_d       = cnt_q;
      rsp_valid_d = '0;
      rsp_rdata_d = rsp_rdata_q;
      arm_d       = 1'b1;

      case (state_q)
         IDLE, ACK: begin
            state_d = IDLE;
            if (can_accept && grant_any) begin
               state_d = ISSUE;
               ptr_d   = grant_idx;
               owner_d = grant;
               for (int i = 0; i < N_REQ; i++) begin
                  if (grant[i]) begin
                     we_d    = bus.req_we[i];
                     addr_d  = bus.req_addr[i];
                     wdata_d = bus.req_wdata[i];
                  end
               end
               // Strobes are registered, so they are set on the way into ISSUE.
               wen_d = we_d;
               ren_d = !we_d;
            end
         end

         ISSUE: begin
            if (we_q) begin
               state_d     = ACK;
               rsp_valid_d = owner_q;
               rsp_rdata_d = '0;
            end else begin
               state_d = WAIT;
               cnt_d   = Cnt_init;
            end
         end

         WAIT: begin
            if (cnt_q == '0) begin
               state_d     = ACK;
               rsp_valid_d = owner_q;
               rsp_rdata_d = bus.dbg_rdata;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers are updated with non-blocking assignments only, so
   // every flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= req_id_t'(N_REQ - 1);
         owner_q     <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wen_q       <= 1'b0;
         ren_q       <= 1'b0;
         cnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         arm_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wen_q       <= wen_d;
         ren_q       <= ren_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         arm_q       <= arm_d;
      end
   end

   assign bus.dbg_addr  = addr_q;
   assign bus.dbg_wdata = wdata_q;
   assign bus.dbg_wen   = wen_q;
   assign bus.dbg_ren   = ren_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_dbg_arb.sv
// Scoreboard bench for dbg_arb: three builds (2 masters, 3 masters, read
// latency 3) share one clock; a bus model returns data exactly RD_LAT edges after ren.
module tb_dbg_arb import dbg_arb_pkg::*;;

   localparam int LAT [3] = '{2, 2, 3};

   typedef struct {
      int    m;
      byte_t data;
      int    cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_chk;
   int   n_fail;

   logic  [2:0] v [3];
   logic  [2:0] we [3];
   addr_t [2:0] a [3];
   byte_t [2:0] wd [3];
   logic  [2:0] rdy [3];
   logic  [2:0] rv [3];
   byte_t       rd [3];
   addr_t       ba [3];
   logic        bw [3];
   logic        br [3];
   logic        bz [3];
   byte_t       bwd [3];
   byte_t       brd [3];

   byte_t mem  [3][1024];
   bit    wvld [3][1024];
   bit    pv   [3][4];
   byte_t pd   [3][4];

   exp_t  sb [3][$];
   int    gl [3][$];
   int    la [3];
   logic  lw [3];
   addr_t lad [3];
   byte_t lwd [3];

   dbg_arb_if #(.N_REQ(2)) i0 ();
   dbg_arb_if #(.N_REQ(3)) i1 ();
   dbg_arb_if #(.N_REQ(2)) i2 ();

   dbg_arb #(.N_REQ(2), .RD_LAT(LAT[0])) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave), .busy(bz[0]));
   dbg_arb #(.N_REQ(3), .RD_LAT(LAT[1])) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave), .busy(bz[1]));
   dbg_arb #(.N_REQ(2), .RD_LAT(LAT[2])) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave), .busy(bz[2]));

   assign i0.req_valid = v[0][1:0];
   assign i0.req_we    = we[0][1:0];
   assign i0.req_addr  = a[0][1:0];
   assign i0.req_wdata = wd[0][1:0];
   assign i0.dbg_rdata = brd[0];
   assign rdy[0] = {1'b0, i0.req_ready};
   assign rv[0]  = {1'b0, i0.rsp_valid};
   assign rd[0]  = i0.rsp_rdata;
   assign ba[0]  = i0.dbg_addr;
   assign bw[0]  = i0.dbg_wen;
   assign br[0]  = i0.dbg_ren;
   assign bwd[0] = i0.dbg_wdata;

   assign i1.req_valid = v[1];
   assign i1.req_we    = we[1];
   assign i1.req_addr  = a[1];
   assign i1.req_wdata = wd[1];
   assign i1.dbg_rdata = brd[1];
   assign rdy[1] = i1.req_ready;
   assign rv[1]  = i1.rsp_valid;
   assign rd[1]  = i1.rsp_rdata;
   assign ba[1]  = i1.dbg_addr;
   assign bw[1]  = i1.dbg_wen;
   assign br[1]  = i1.dbg_ren;
   assign bwd[1] = i1.dbg_wdata;

   assign i2.req_valid = v[2][1:0];
   assign i2.req_we    = we[2][1:0];
   assign i2.req_addr  = a[2][1:0];
   assign i2.req_wdata = wd[2][1:0];
   assign i2.dbg_rdata = brd[2];
   assign rdy[2] = {1'b0, i2.req_ready};
   assign rv[2]  = {1'b0, i2.rsp_valid};
   assign rd[2]  = i2.rsp_rdata;
   assign ba[2]  = i2.dbg_addr;
   assign bw[2]  = i2.dbg_wen;
   assign br[2]  = i2.dbg_ren;
   assign bwd[2] = i2.dbg_wdata;

   // Read data is only valid for the single cycle RD_LAT edges after ren.
   assign brd[0] = pv[0][LAT[0]-1] ? pd[0][LAT[0]-1] : 8'hEE;
   assign brd[1] = pv[1][LAT[1]-1] ? pd[1][LAT[1]-1] : 8'hEE;
   assign brd[2] = pv[2][LAT[2]-1] ? pd[2][LAT[2]-1] : 8'hEE;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic byte_t rd_model(input int d, input addr_t ad);
      if (wvld[d][ad]) return mem[d][ad];
      if (ad == Ctl_pc_lo)   return 8'hA5;
      if (ad == Ctl_sys_rst) return 8'h07;
      if (ad == Io_rom_out2) return 8'h3C;
      return ad.idx ^ 8'h5A;
   endfunction

   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (bw[d]) begin
            mem[d][ba[d]]  <= bwd[d];
            wvld[d][ba[d]] <= 1'b1;
         end
         pv[d][0] <= br[d];
         pd[d][0] <= rd_model(d, ba[d]);
         for (int k = 1; k < 4; k++) begin
            pv[d][k] <= pv[d][k-1];
            pd[d][k] <= pd[d][k-1];
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic check_zero(input int d);
      check("rst_req_ready", rdy[d], 0);
      check("rst_rsp_valid", rv[d], 0);
      check("rst_rsp_rdata", rd[d], 0);
      check("rst_dbg_addr", ba[d], 0);
      check("rst_dbg_wen", bw[d], 0);
      check("rst_dbg_ren", br[d], 0);
      check("rst_dbg_wdata", bwd[d], 0);
      check("rst_busy", bz[d], 0);
   endtask

   // Raise a request, wait (bounded) for ready, then push the expected response.
   task automatic do_req(input int d, input int m, input logic w, input addr_t ad,
                         input byte_t wdat, input byte_t exp);
      int   t;
      exp_t e;
      v[d][m]  = 1'b1;
      we[d][m] = w;
      a[d][m]  = ad;
      wd[d][m] = wdat;
      #1;
      t = 0;
      while (!rdy[d][m] && t < 64) begin
         @(negedge clk);
         #1;
         t++;
      end
      check("ready_seen", rdy[d][m], 1);
      if (!rdy[d][m]) begin
         v[d][m] = 1'b0;
         return;
      end
      check("ready_onehot", rdy[d], 32'd1 << m);
      la[d]  = cyc;
      lw[d]  = w;
      lad[d] = ad;
      lwd[d] = wdat;
      gl[d].push_back(m);
      e.m    = m;
      e.data = w ? 8'h00 : exp;
      e.cyc  = cyc + (w ? 2 : 2 + LAT[d]);
      sb[d].push_back(e);
      @(negedge clk);
      v[d][m] = 1'b0;
   endtask

   task automatic wait_idle(input int d);
      int t;
      t = 0;
      while (sb[d].size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      check("drain", sb[d].size(), 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      logic ew;
      logic er;
      #1;
      if (rst_n) begin
         for (int d = 0; d < 3; d++) begin
            ew = (cyc == la[d] + 1) && lw[d];
            er = (cyc == la[d] + 1) && !lw[d];
            check("dbg_wen", bw[d], ew);
            check("dbg_ren", br[d], er);
            if (ew) check("dbg_wdata", bwd[d], lwd[d]);
            if (!lw[d] && cyc >= la[d] + 1 && cyc <= la[d] + 1 + LAT[d])
               check("addr_hold", ba[d], lad[d]);
            if (rv[d] != 0) begin
               if (sb[d].size() == 0) begin
                  check("rsp_unexpected", rv[d], 0);
               end else begin
                  e = sb[d].pop_front();
                  check("rsp_owner", rv[d], 32'd1 << e.m);
                  check("rsp_rdata", rd[d], e.data);
                  check("rsp_cycle", cyc, e.cyc);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got time limit, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      for (int d = 0; d < 3; d++) begin
         v[d]  = '0;
         we[d] = '0;
         a[d]  = '0;
         wd[d] = '0;
         la[d] = -10;
         lw[d] = 1'b0;
      end
      #1;
      for (int d = 0; d < 3; d++) check_zero(d);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Single read from master 0 on the default build.
      do_req(0, 0, 1'b0, Ctl_pc_lo, 8'h00, 8'hA5);
      wait_idle(0);

      // Master 1 write/read-back pairs; the second of each pair is accepted in ACK.
      do_req(0, 1, 1'b1, Ctl_sys_rst, 8'h00, 8'h00);
      do_req(0, 1, 1'b0, Ctl_sys_rst, 8'h00, 8'h00);
      do_req(0, 1, 1'b1, Ctl_sys_rst, 8'h05, 8'h00);
      do_req(0, 1, 1'b0, Ctl_sys_rst, 8'h00, 8'h05);
      wait_idle(0);

      // Both masters request continuously: grants must alternate.
      gl[0].delete();
      fork
         for (int k = 0; k < 4; k++)
            do_req(0, 0, 1'b0, mk_addr(SEG_ROM, 8'(32 + k)), 8'h00, 8'(32 + k) ^ 8'h5A);
         for (int k = 0; k < 4; k++)
            do_req(0, 1, 1'b0, mk_addr(SEG_RAM, 8'(48 + k)), 8'h00, 8'(48 + k) ^ 8'h5A);
      join
      wait_idle(0);
      check("fair_count", gl[0].size(), 8);
      for (int i = 0; i < 8 && i < gl[0].size(); i++) check("fair_order", gl[0][i], i % 2);

      // Three masters: after master 2 is served, 1 and 2 together -> 1 then 2.
      gl[1].delete();
      do_req(1, 0, 1'b0, mk_addr(SEG_ROM, 8'h01), 8'h00, 8'h01 ^ 8'h5A);
      do_req(1, 2, 1'b1, mk_addr(SEG_RAM, 8'h02), 8'h77, 8'h00);
      fork
         do_req(1, 1, 1'b0, mk_addr(SEG_RAM, 8'h02), 8'h00, 8'h77);
         do_req(1, 2, 1'b0, mk_addr(SEG_ROM, 8'h03), 8'h00, 8'h03 ^ 8'h5A);
      join
      wait_idle(1);
      check("rr3_count", gl[1].size(), 4);
      if (gl[1].size() == 4) begin
         check("rr3_g0", gl[1][0], 0);
         check("rr3_g1", gl[1][1], 2);
         check("rr3_g2", gl[1][2], 1);
         check("rr3_g3", gl[1][3], 2);
      end

      // Read latency 3 build.
      do_req(2, 0, 1'b0, Io_rom_out2, 8'h00, 8'h3C);
      wait_idle(2);

      // Reset during WAIT of a ROM read: dropped, then master 0 wins first.
      do_req(0, 0, 1'b0, mk_addr(SEG_ROM, 8'h40), 8'h00, 8'h40 ^ 8'h5A);
      @(negedge clk);
      v[0][0]  = 1'b1;
      we[0][0] = 1'b0;
      a[0][0]  = mk_addr(SEG_ROM, 8'h41);
      v[0][1]  = 1'b1;
      we[0][1] = 1'b1;
      a[0][1]  = mk_addr(SEG_RAM, 8'h01);
      wd[0][1] = 8'h99;
      #2;
      check("busy_before_rst", bz[0], 1);
      rst_n = 1'b0;
      #1;
      check_zero(0);
      sb[0].delete();
      gl[0].delete();
      repeat (4) @(negedge clk);
      check("rst_ready_held", rdy[0], 0);
      rst_n = 1'b1;
      fork
         do_req(0, 0, 1'b0, mk_addr(SEG_ROM, 8'h41), 8'h00, 8'h41 ^ 8'h5A);
         do_req(0, 1, 1'b1, mk_addr(SEG_RAM, 8'h01), 8'h99, 8'h00);
      join
      wait_idle(0);
      check("post_rst_count", gl[0].size(), 2);
      if (gl[0].size() == 2) begin
         check("post_rst_first", gl[0][0], 0);
         check("post_rst_second", gl[0][1], 1);
      end
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
